// File: rtl/mux_tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Mode and FSM state encodings shared by the mux_tdm block.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lsb_trunc.sv
`default_nettype none
// ============================================================================
// Module      : lsb_trunc
// Description : Optionally forces the TRUNC_W least-significant bits to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_trunc #(
    parameter int DATA_W  = 8,
    parameter int TRUNC_W = 2
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic              en,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (TRUNC_W == 0) begin : g_pass
            assign out_data = in_data;
        end else begin : g_trunc
            assign out_data = en ? {in_data[DATA_W-1:TRUNC_W], {TRUNC_W{1'b0}}}
                                 : in_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mux_tdm.sv
`default_nettype none
// ============================================================================
// Module      : mux_tdm
// Description : N_CH-channel registered mux with direct select and scan
//               (channel serialisation) modes, valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tdm
    import mux_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int DATA_W  = 8,
    parameter  int TRUNC_W = 2,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     approx_en,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    state_t                   r_state,        w_state_nxt;
    logic [N_CH*DATA_W-1:0]   r_cap,          w_cap_nxt;
    logic                     r_cap_approx,   w_cap_approx_nxt;
    logic [DATA_W-1:0]        r_out_data,     w_out_data_nxt;
    logic [SEL_W-1:0]         r_out_ch,       w_out_ch_nxt;
    logic                     r_out_valid,    w_out_valid_nxt;
    logic                     r_out_last,     w_out_last_nxt;

    logic                     w_in_ready;
    logic                     w_in_hs;
    logic                     w_out_hs;
    logic [SEL_W-1:0]         w_ch_inc;
    logic [DATA_W-1:0]        w_pick_data;
    logic                     w_pick_en;
    logic [DATA_W-1:0]        w_trunc_data;

    // Out-of-range indices (non-power-of-2 N_CH) select zero.
    function automatic logic [DATA_W-1:0] pick_ch(
        input logic [N_CH*DATA_W-1:0] vec,
        input logic [SEL_W-1:0]       idx
    );
        pick_ch = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                pick_ch = vec[k*DATA_W +: DATA_W];
            end
        end
    endfunction

    assign w_in_ready = (r_state == ST_IDLE) ? (!r_out_valid || out_ready)
                                             : (r_out_last && out_ready);
    assign w_in_hs    = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_ch_inc   = r_out_ch + 1'b1;

    // A new vector feeds the output path directly; otherwise the next scan beat.
    always_comb begin
        w_pick_data = '0;
        w_pick_en   = 1'b0;
        if (w_in_hs) begin
            w_pick_en   = approx_en;
            w_pick_data = (mode == MODE_SCAN) ? in_data[DATA_W-1:0]
                                              : pick_ch(in_data, sel);
        end else begin
            w_pick_en   = r_cap_approx;
            w_pick_data = pick_ch(r_cap, w_ch_inc);
        end
    end

    lsb_trunc #(
        .DATA_W  (DATA_W),
        .TRUNC_W (TRUNC_W)
    ) u_lsb_trunc (
        .in_data  (w_pick_data),
        .en       (w_pick_en),
        .out_data (w_trunc_data)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_cap_nxt        = r_cap;
        w_cap_approx_nxt = r_cap_approx;
        w_out_data_nxt   = r_out_data;
        w_out_ch_nxt     = r_out_ch;
        w_out_valid_nxt  = r_out_valid;
        w_out_last_nxt   = r_out_last;

        case (r_state)
            ST_IDLE: begin
                if (w_out_hs) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (w_out_hs) begin
                    if (r_out_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                    end else begin
                        w_out_ch_nxt    = w_ch_inc;
                        w_out_data_nxt  = w_trunc_data;
                        w_out_last_nxt  = (w_ch_inc == SEL_W'(N_CH - 1));
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Acceptance overrides the above; in SCAN it can only coincide with the last beat.
        if (w_in_hs) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_trunc_data;
            if (mode == MODE_SCAN) begin
                w_state_nxt      = ST_SCAN;
                w_cap_nxt        = in_data;
                w_cap_approx_nxt = approx_en;
                w_out_ch_nxt     = '0;
                w_out_last_nxt   = 1'b0;
            end else begin
                w_state_nxt      = ST_IDLE;
                w_out_ch_nxt     = sel;
                w_out_last_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cap        <= '0;
            r_cap_approx <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cap        <= w_cap_nxt;
            r_cap_approx <= w_cap_approx_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_ch     <= w_out_ch_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_last   <= w_out_last_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_mux_tdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tdm
// Description : Scoreboard bench for mux_tdm (N_CH=4) plus an N_CH=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tdm;

    localparam logic [31:0] c_vec  = 32'hD43C_A511;
    localparam logic [31:0] c_vec2 = 32'h4433_2201;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
        logic       l;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        approx_en;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  out3_data;
    logic [1:0]  out3_ch;
    logic        out3_valid;
    logic        out3_last;

    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       q[$];
    beat_t       b;
    logic [7:0]  e[4];

    mux_tdm #(.N_CH(4), .DATA_W(8), .TRUNC_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .approx_en (approx_en),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    mux_tdm #(.N_CH(3), .DATA_W(8), .TRUNC_W(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .approx_en (approx_en),
        .sel       (sel),
        .in_data   (in_data[23:0]),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out3_data),
        .out_ch    (out3_ch),
        .out_valid (out3_valid),
        .out_ready (out_ready),
        .out_last  (out3_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tr(input logic [7:0] x, input logic en);
        return en ? (x & 8'hFC) : x;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && !(out_valid == 1'b0 && q.size() == 0); i++) cyc();
        check("drain_done", 32'(out_valid == 1'b0 && q.size() == 0), 32'd1);
    endtask

    always @(negedge rst_n) q.delete();

    // Scoreboard: pop on output handshake, push expected beats on input handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("sb_queue_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    b = q.pop_front();
                    check("sb_data", 32'(out_data), 32'(b.d));
                    check("sb_ch",   32'(out_ch),   32'(b.c));
                    check("sb_last", 32'(out_last), 32'(b.l));
                end
            end
            if (in_valid && in_ready) begin
                if (mode) begin
                    for (int i = 0; i < 4; i++)
                        q.push_back('{d: tr(in_data[i*8 +: 8], approx_en), c: 2'(i), l: (i == 3)});
                end else begin
                    q.push_back('{d: tr(in_data[sel*8 +: 8], approx_en), c: sel, l: 1'b1});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e = '{8'h11, 8'hA5, 8'h3C, 8'hD4};
        rst_n = 1'b0; mode = 1'b0; approx_en = 1'b0; sel = 2'd0;
        in_data = c_vec; in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ch",    32'(out_ch),    32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while a beat is held
        cyc();
        out_ready = 1'b0; mode = 1'b0; sel = 2'd3; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_data",  32'(out_data),  32'hD4);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_data",  32'(out_data),  32'd0);
        check("async_ch",    32'(out_ch),    32'd0);
        check("async_last",  32'(out_last),  32'd0);
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Direct mode, back to back
        cyc();
        mode = 1'b0; sel = 2'd2; in_valid = 1'b1;
        cyc();
        sel = 2'd0;
        @(negedge clk);
        check("dir_data",  32'(out_data),  32'h3C);
        check("dir_ch",    32'(out_ch),    32'd2);
        check("dir_valid", 32'(out_valid), 32'd1);
        check("dir_last",  32'(out_last),  32'd1);
        check("dir_ready", 32'(in_ready),  32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("dir2_data",  32'(out_data),  32'h11);
        check("dir2_valid", 32'(out_valid), 32'd1);
        drain();

        // Scan mode with a second vector held valid
        mode = 1'b1; approx_en = 1'b0; in_data = c_vec; in_valid = 1'b1;
        cyc();
        in_data = c_vec2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("scan_data",  32'(out_data), 32'(e[i]));
            check("scan_ch",    32'(out_ch),   32'(i));
            check("scan_last",  32'(out_last), 32'(i == 3));
            check("scan_ready", 32'(in_ready), 32'(i == 3));
            cyc();
        end
        @(negedge clk);
        check("b2b_data", 32'(out_data), 32'h01);
        check("b2b_ch",   32'(out_ch),   32'd0);
        check("b2b_last", 32'(out_last), 32'd0);
        cyc();
        in_valid = 1'b0;
        drain();

        // Backpressure at beat 1
        mode = 1'b1; in_data = c_vec; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_beat0", 32'(out_data), 32'h11);
        cyc();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_data",  32'(out_data), 32'hA5);
            check("bp_hold_ch",    32'(out_ch),   32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(out_data), 32'hA5);
        cyc();
        @(negedge clk);
        check("bp_resume_data", 32'(out_data), 32'h3C);
        check("bp_resume_ch",   32'(out_ch),   32'd2);
        drain();

        // Approximate mode, direct
        approx_en = 1'b1; mode = 1'b0; sel = 2'd1; in_valid = 1'b1;
        cyc();
        sel = 2'd0;
        @(negedge clk);
        check("apx_sel1", 32'(out_data), 32'hA4);
        cyc();
        sel = 2'd3;
        @(negedge clk);
        check("apx_sel0", 32'(out_data), 32'h10);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("apx_sel3", 32'(out_data), 32'hD4);
        drain();

        // Scan with approx_en/mode toggled mid-scan
        approx_en = 1'b0; mode = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; approx_en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("apx_scan_data", 32'(out_data), 32'(e[i]));
            cyc();
        end
        drain();

        // Reset mid-scan
        approx_en = 1'b0; mode = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("rs_beat0", 32'(out_data), 32'h11);
        cyc();
        @(negedge clk);
        check("rs_beat1", 32'(out_data), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_ch",    32'(out_ch),    32'd0);
        check("rs_data",  32'(out_data),  32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            cyc();
            @(negedge clk);
            check("rs_no_residual", 32'(out_valid), 32'd0);
        end
        cyc();
        mode = 1'b0; sel = 2'd2; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("rs_idle_direct", 32'(out_data), 32'h3C);
        drain();

        // N_CH=3 instance: out-of-range select and scan length
        mode = 1'b0; approx_en = 1'b0; sel = 2'd3; in_valid3 = 1'b1;
        cyc();
        sel = 2'd2;
        @(negedge clk);
        check("n3_oor_data",  32'(out3_data),  32'd0);
        check("n3_oor_ch",    32'(out3_ch),    32'd3);
        check("n3_oor_valid", 32'(out3_valid), 32'd1);
        cyc();
        in_valid3 = 1'b0;
        @(negedge clk);
        check("n3_sel2_data", 32'(out3_data), 32'h3C);
        check("n3_sel2_ch",   32'(out3_ch),   32'd2);
        cyc();
        mode = 1'b1; in_valid3 = 1'b1;
        cyc();
        in_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("n3_scan_data", 32'(out3_data), 32'(e[i]));
            check("n3_scan_last", 32'(out3_last), 32'(i == 2));
            cyc();
        end
        @(negedge clk);
        check("n3_scan_done", 32'(out3_valid), 32'd0);

        check("sb_empty_end", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
